lfsr_draw_gen: RTL and testbench
================================

Name: lfsr_draw_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator with a bounded-range draw port.
- Serves as the random source for piece selection and any other game randomness.
- The register free-runs on `en`, which is driven by player/tick activity for entropy.
- Consumers pull values in [0, RANGE-1] over a valid/ready handshake. Values come from rejection sampling, with a guaranteed bound on rejections.

Parameters:
- WIDTH, 13: LFSR register width; legal range 3..32.
- TAPS, 13'h100D: feedback mask. Bit i set means reg[i] is XORed into feedback. Bit WIDTH-1 must be set.
- SEED, 13'h1CAB: reset and recovery value. Must be nonzero.
- STEPS, 1: LFSR shifts per advance (1..WIDTH), unrolled combinationally.
- RANGE, 7: draw range size. Must satisfy 2 ≤ RANGE ≤ 2^(WIDTH-1).
- MAX_REJECT, 4: consecutive rejections allowed before fallback mapping.
- Localparam VAL_W = clog2(RANGE).

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: advance the LFSR by STEPS this cycle.
- load, in, 1: load seed_in into the register.
- seed_in, in, WIDTH: seed value.
- state_out, out, WIDTH: current register contents.
- draw_valid, out, 1: draw_value holds an accepted value.
- draw_ready, in, 1: consumer accepts draw_value.
- draw_value, out, VAL_W: random value in [0, RANGE-1].
- lockup, out, 1: one-cycle pulse when an all-zero state is replaced by SEED.

Behaviour:
- **Reset:** reg = SEED, FSM = FILL, draw_valid = 0, draw_value = 0, lockup = 0, reject_cnt = 0.
- **Single step:** fb = XOR of (reg & TAPS); reg_next = {reg[WIDTH-2:0], fb}. An advance applies this STEPS times within one cycle.
- **Register update priority:**
  1. load: reg = seed_in, or SEED if seed_in == 0.
  2. Otherwise, if (en or FSM == FILL): reg = advanced value. An advance is STEPS shifts, never doubled when both en and FILL are true.
  3. Otherwise: hold.
- **Zero lock:** if a loaded or advanced value is all zeros, the register takes SEED instead and lockup pulses high for exactly one cycle.
- **FSM state FILL:**
  - Each cycle the register advances and cand = low VAL_W bits of the new register value.
  - Accept if cand < RANGE: draw_value <= cand, draw_valid <= 1, reject_cnt <= 0, go to HOLD.
  - Otherwise, if reject_cnt == MAX_REJECT: accept cand − RANGE (always < RANGE, given the RANGE constraint) and go to HOLD.
  - Otherwise: reject_cnt++, stay in FILL.
- **FSM state HOLD:**
  - draw_value is stable and draw_valid = 1. The register advances only on en.
  - When draw_valid && draw_ready at a clock edge: draw_valid <= 0, go to FILL.
- **Latency:** after a handshake, draw_valid is low for at least 1 cycle. After rst_n deasserts, the first FILL evaluation occurs in the first clock cycle.
- **Load while FILL:** sampling continues next cycle from the loaded seed, and reject_cnt is unchanged. A candidate is still evaluated in the load cycle, taken from the loaded value.
- **Load while HOLD:** draw_value and draw_valid are unaffected.
- **draw_ready while FILL:** ignored.
- **Mid-operation reset:** an asynchronous rst_n assertion returns all state to reset values immediately.

Optional Feature:
- Macro: LFSR_DRAW_NO_REPEAT_EN.
- **Defined:** the block keeps last_value, the most recent delivered draw, which is invalid after reset. In FILL, a cand equal to a valid last_value is treated as a rejection and increments reject_cnt. The fallback path may still return a repeat.
- **Undefined:** no history register; plain rejection as above.

Decomposition:
- Package lfsr_draw_pkg contains:
  - the FSM state enum {FILL, HOLD};
  - default TAPS/SEED constants for widths 8, 13, 16 and 32;
  - the function lfsr_step(reg, taps), returning one shift.
- Natural sub-module: lfsr_core. It holds WIDTH/TAPS/SEED/STEPS, the load/advance/zero-lock logic, and the lockup output. The draw FSM wraps lfsr_core.

Test Plan (defaults unless stated, STEPS=1):
- Reset, en=1 for one cycle with draw_ready held low → state_out 0x1CAB → 0x1957 after that edge; second advance 0x1957 → 0x12AF.
- Reset, en=0, draw_ready=0 → FILL rejects 0x1957 (cand 7) and 0x12AF (cand 7), then accepts 0x055E; draw_valid rises after the 3rd edge with draw_value = 6.
- MAX_REJECT=1, same start → cycle 1 rejects 7; cycle 2 cand 7 falls back → draw_value = 0, valid after the 2nd edge.
- load=1, seed_in=0 → register = 0x1CAB, lockup high for exactly one cycle; load with seed_in=0x0001 → state_out = 0x0001 next cycle, no lockup.
- In HOLD with draw_value=6, draw_ready held high continuously → one handshake per accepted value; draw_valid low for ≥1 cycle between values; every draw_value < 7 over 10,000 draws.
- rst_n pulsed low asynchronously mid-FILL (between edges) → outputs clear immediately; after release, the sequence repeats identically from 0x1CAB.

Source files
------------

// File: rtl/lfsr_draw_pkg.sv
// Shared types and helpers for the LFSR draw generator.
// Combinational helpers only, no latency.
// No flow control at this level.
package lfsr_draw_pkg;

    // Draw FSM: FILL samples candidates, HOLD presents an accepted value
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } draw_state_t;

    // Maximal-length feedback masks (bit i set feeds reg[i] into the XOR)
    // and nonzero default seeds for common widths
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [7:0]  SEED_8  = 8'h5A;
    localparam logic [12:0] TAPS_13 = 13'h100D;
    localparam logic [12:0] SEED_13 = 13'h1CAB;
    localparam logic [15:0] TAPS_16 = 16'hD008;
    localparam logic [15:0] SEED_16 = 16'hACE1;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [31:0] SEED_32 = 32'hDEAD_BEEF;

    // One Fibonacci shift: new bit 0 is the XOR of the tapped bits.
    // Operands are zero-extended; the caller keeps the low WIDTH bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] r, input logic [31:0] taps);
        return {r[30:0], ^(r & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR register with load, multi-step advance and all-zero recovery.
// Register updates one cycle after load/adv; cand_out is combinational.
// No backpressure: advances whenever adv is high, load takes priority.
module lfsr_core
    import lfsr_draw_pkg::*;
#(
    parameter int               WIDTH  = 13,
    parameter logic [WIDTH-1:0] TAPS   = 13'h100D,
    parameter logic [WIDTH-1:0] SEED   = 13'h1CAB,
    parameter int               STEPS  = 1,
    parameter int               CAND_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed_in,
    output logic [WIDTH-1:0]  state_out,
    output logic [CAND_W-1:0] cand_out,
    output logic              lockup
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] adv_val;
    logic [WIDTH-1:0] raw_val;
    logic [WIDTH-1:0] nxt_val;
    logic             upd;
    logic             zero_hit;
    logic             lockup_q;

    // Unrolled STEPS-fold shift of the current register
    always_comb begin
        adv_val = reg_q;
        for (int i = 0; i < STEPS; i++) begin
            adv_val = WIDTH'(lfsr_step(32'(adv_val), 32'(TAPS)));
        end
    end

    // Load beats advance; any written all-zero value is replaced by SEED
    always_comb begin
        raw_val = reg_q;
        upd     = 1'b0;
        if (load) begin
            raw_val = seed_in;
            upd     = 1'b1;
        end else if (adv) begin
            raw_val = adv_val;
            upd     = 1'b1;
        end
        zero_hit = upd && (raw_val == '0);
        nxt_val  = zero_hit ? SEED : raw_val;
    end

    // Register state and the one-cycle lockup flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q    <= SEED;
            lockup_q <= 1'b0;
        end else begin
            reg_q    <= nxt_val;
            lockup_q <= zero_hit;
        end
    end

    assign state_out = reg_q;
    assign cand_out  = nxt_val[CAND_W-1:0];
    assign lockup    = lockup_q;

endmodule

// File: rtl/lfsr_draw_gen.sv
// LFSR random source with a [0, RANGE-1] rejection-sampled draw port (LFSR_DRAW_NO_REPEAT_EN rejects repeats).
// First draw_valid 1..MAX_REJECT+1 cycles after reset or after a handshake.
// draw_value held with draw_valid until draw_ready; draw_ready ignored while sampling.
module lfsr_draw_gen
    import lfsr_draw_pkg::*;
#(
    parameter int               WIDTH      = 13,
    parameter logic [WIDTH-1:0] TAPS       = 13'h100D,
    parameter logic [WIDTH-1:0] SEED       = 13'h1CAB,
    parameter int               STEPS      = 1,
    parameter int               RANGE      = 7,
    parameter int               MAX_REJECT = 4,
    localparam int              VAL_W      = $clog2(RANGE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state_out,
    output logic             draw_valid,
    input  logic             draw_ready,
    output logic [VAL_W-1:0] draw_value,
    output logic             lockup
);

    localparam int               RC_W    = (MAX_REJECT < 1) ? 1 : $clog2(MAX_REJECT + 1);
    localparam logic [VAL_W:0]   RANGE_X = (VAL_W + 1)'(RANGE);
    localparam logic [VAL_W-1:0] RANGE_V = VAL_W'(RANGE);

    draw_state_t      state_q, state_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [VAL_W-1:0] cand;
    logic             in_range;
    logic             at_limit;
    logic             repeat_hit;

    // The register free-runs on en and is always stepped while sampling
    lfsr_core #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .SEED   (SEED),
        .STEPS  (STEPS),
        .CAND_W (VAL_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (en || (state_q == FILL)),
        .load      (load),
        .seed_in   (seed_in),
        .state_out (state_out),
        .cand_out  (cand),
        .lockup    (lockup)
    );

    assign in_range = {1'b0, cand} < RANGE_X;
    assign at_limit = (rcnt_q == RC_W'(MAX_REJECT));

`ifdef LFSR_DRAW_NO_REPEAT_EN
    logic [VAL_W-1:0] last_q;
    logic             last_vld_q;

    // Remember the most recently delivered value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if ((state_q == HOLD) && draw_ready) begin
            last_q     <= value_q;
            last_vld_q <= 1'b1;
        end
    end

    assign repeat_hit = last_vld_q && (cand == last_q);
`else
    assign repeat_hit = 1'b0;
`endif

    // Sampling decision: accept, fall back after MAX_REJECT misses, or retry
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            FILL: begin
                if (in_range && !repeat_hit) begin
                    value_d = cand;
                    rcnt_d  = '0;
                    state_d = HOLD;
                end else if (at_limit) begin
                    // cand < 2*RANGE, so one subtraction always lands in range
                    value_d = in_range ? cand : (cand - RANGE_V);
                    rcnt_d  = '0;
                    state_d = HOLD;
                end else begin
                    rcnt_d  = rcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (draw_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // FSM, held value and rejection counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            value_q <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign draw_valid = (state_q == HOLD);
    assign draw_value = value_q;

endmodule

// File: tb/tb_lfsr_draw_gen.sv
// Scoreboard bench for lfsr_draw_gen: directed expected draws queued by the
// stimulus, popped and compared by a negedge monitor on every handshake.
module tb_lfsr_draw_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [12:0] seed_in;
    logic        draw_ready;

    logic [12:0] state_out, state_out2;
    logic        draw_valid, draw_valid2;
    logic [2:0]  draw_value, draw_value2;
    logic        lockup, lockup2;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit free_run = 1'b0;
    bit prev_hs = 1'b0;
    int hs_cnt = 0;

    lfsr_draw_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .state_out  (state_out),
        .draw_valid (draw_valid),
        .draw_ready (draw_ready),
        .draw_value (draw_value),
        .lockup     (lockup)
    );

    lfsr_draw_gen #(.MAX_REJECT(1)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .state_out  (state_out2),
        .draw_valid (draw_valid2),
        .draw_ready (draw_ready),
        .draw_value (draw_value2),
        .lockup     (lockup2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes are decided by the values seen at the negedge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) chk("gap_after_handshake", 32'(draw_valid), 32'd0);
            prev_hs = draw_valid && draw_ready;
            if (prev_hs) begin
                hs_cnt++;
                if (exp_q.size() > 0)
                    chk("draw_value", 32'(draw_value), 32'(exp_q.pop_front()));
                else if (free_run)
                    chk("draw_in_range", 32'(draw_value < 3'd7), 32'd1);
                else
                    chk("unexpected_draw", 32'(draw_valid), 32'd0);
            end
        end
    end

    task automatic drain();
        int n = 0;
        draw_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        draw_ready = 1'b0;
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0; draw_ready = 1'b0;
        #1 rst_n = 1'b0;
        #6;
        chk("reset_state", 32'(state_out), 32'h1CAB);
        chk("reset_valid", 32'(draw_valid), 32'd0);
        chk("reset_value", 32'(draw_value), 32'd0);
        chk("reset_lockup", 32'(lockup), 32'd0);

        // Release between edges; en high for the first edge must not double-step
        #5 rst_n = 1'b1; en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        chk("step1_state", 32'(state_out), 32'h1957);
        chk("step1_valid", 32'(draw_valid), 32'd0);
        chk("step1_valid_mr1", 32'(draw_valid2), 32'd0);
        @(posedge clk); #1;
        chk("step2_state", 32'(state_out), 32'h12AF);
        chk("step2_valid", 32'(draw_valid), 32'd0);
        chk("mr1_state", 32'(state_out2), 32'h12AF);
        chk("mr1_valid", 32'(draw_valid2), 32'd1);
        chk("mr1_fallback_value", 32'(draw_value2), 32'd0);
        @(posedge clk); #1;
        chk("step3_state", 32'(state_out), 32'h055E);
        chk("step3_valid", 32'(draw_valid), 32'd1);
        chk("step3_value", 32'(draw_value), 32'd6);
        chk("step3_lockup", 32'(lockup), 32'd0);

        // Load zero while holding: SEED restored, single lockup pulse, draw untouched
        load = 1'b1; seed_in = 13'h0000;
        @(posedge clk); #1 load = 1'b0;
        chk("load0_state", 32'(state_out), 32'h1CAB);
        chk("load0_lockup", 32'(lockup), 32'd1);
        chk("load0_lockup_mr1", 32'(lockup2), 32'd1);
        chk("load0_valid", 32'(draw_valid), 32'd1);
        chk("load0_value", 32'(draw_value), 32'd6);
        @(posedge clk); #1;
        chk("load0_lockup_drop", 32'(lockup), 32'd0);
        chk("hold_no_advance", 32'(state_out), 32'h1CAB);
        load = 1'b1; seed_in = 13'h0001;
        @(posedge clk); #1 load = 1'b0;
        chk("load1_state", 32'(state_out), 32'h0001);
        chk("load1_lockup", 32'(lockup), 32'd0);
        chk("load1_value", 32'(draw_value), 32'd6);

        // Continuous ready from seed 1: 0x3,0x7(rej),0xE,0x1C,0x38,0x71,0xE3
        exp_q.push_back(6); exp_q.push_back(3); exp_q.push_back(6);
        exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(3);
        drain();

        // Asynchronous reset while sampling, then the reset sequence must repeat
        #2 rst_n = 1'b0;
        #1;
        chk("areset_state", 32'(state_out), 32'h1CAB);
        chk("areset_valid", 32'(draw_valid), 32'd0);
        chk("areset_value", 32'(draw_value), 32'd0);
        chk("areset_lockup", 32'(lockup), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerun1_state", 32'(state_out), 32'h1957);
        chk("rerun1_valid", 32'(draw_valid), 32'd0);
        @(posedge clk); #1;
        chk("rerun2_state", 32'(state_out), 32'h12AF);
        chk("rerun2_valid", 32'(draw_valid), 32'd0);
        @(posedge clk); #1;
        chk("rerun3_valid", 32'(draw_valid), 32'd1);
        exp_q.push_back(6);
        drain();

        // Long run with ready held and en toggling: every draw must be in range
        hs_cnt = 0;
        free_run = 1'b1;
        draw_ready = 1'b1;
        for (int c = 0; c < 80000; c++) begin
            @(posedge clk); #1;
            en = 1'($urandom_range(0, 1));
            if (hs_cnt >= 10000) break;
        end
        draw_ready = 1'b0;
        en = 1'b0;
        chk("free_run_draw_count", 32'(hs_cnt >= 10000), 32'd1);
        @(posedge clk); #1;
        free_run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
